serial_addsub: RTL and testbench
================================

SERIAL_ADDSUB -- requirements
Module: serial_addsub

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, setting the operand width in bits.
REQ-002 The block SHALL have parameter DIGIT, default 4, setting the bits processed per clock; WIDTH SHALL be an integer multiple of DIGIT, and N = WIDTH/DIGIT.
REQ-003 Port clk SHALL be an input, 1 bit wide: the only clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-005 Port start SHALL be an input, 1 bit wide: request a new operation.
REQ-006 Port input1 SHALL be an input, WIDTH bits wide: operand A, sampled only on an accepted start.
REQ-007 Port input2 SHALL be an input, WIDTH bits wide: operand B, sampled only on an accepted start.
REQ-008 Port S SHALL be an input, 1 bit wide: 0 selects add (A+B), 1 selects subtract (A-B); sampled only on an accepted start.
REQ-009 Port busy SHALL be an output, 1 bit wide: high while an operation is in progress.
REQ-010 Port done SHALL be an output, 1 bit wide: one-cycle pulse when results become valid.
REQ-011 Port sum SHALL be an output, WIDTH bits wide: result modulo 2^WIDTH.
REQ-012 Port outc SHALL be an output, 1 bit wide: carry out of the MSB.
REQ-013 Port borrow SHALL be an output, 1 bit wide: unsigned borrow, equal to S AND NOT outc.
REQ-014 Port overflow SHALL be an output, 1 bit wide: two's-complement overflow, equal to carry into the MSB XOR carry out of the MSB.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-016 In IDLE or DONE, start=1 at a rising edge SHALL be accepted: latch A, B XOR {WIDTH{S}}, carry-in = S, and S; clear the digit counter; go to RUN.
REQ-017 In RUN, each rising edge SHALL add one DIGIT-bit slice, starting with the LSB slice, using the carry saved from the previous slice; it SHALL shift the slice result into the internal result register and increment the counter.
REQ-018 On the edge that processes slice N-1, the FSM SHALL load sum, outc, borrow and overflow together and go to DONE.
REQ-019 Latency SHALL be exactly N clocks from the accepting edge to the edge that raises done (4 clocks for WIDTH=16, DIGIT=4; 16 clocks for DIGIT=1).
REQ-020 busy SHALL be 1 exactly while the state is RUN; done SHALL be 1 exactly while the state is DONE.
REQ-021 From DONE without start, the next edge SHALL return the FSM to IDLE; from DONE with start, it SHALL enter RUN directly, allowing back-to-back operations with no IDLE gap.
REQ-022 start asserted while in RUN SHALL be ignored: operands are not resampled and the operation is neither restarted nor extended.
REQ-023 sum, outc, borrow and overflow SHALL hold their last completed values until the next completion; intermediate slice results SHALL never appear on these outputs.
REQ-024 overflow SHALL be computed for both add and subtract; borrow SHALL be 0 whenever S=0.
REQ-025 Changes on input1, input2 or S after the accepting edge SHALL NOT affect the operation in progress.

Reset
REQ-026 rst_n=0 SHALL immediately force the FSM to IDLE and clear the counter, busy, done, sum, outc, borrow, overflow and all internal registers to 0, regardless of clk.
REQ-027 A reset during RUN SHALL abort the operation; no done pulse SHALL follow, and the outputs SHALL read 0.
REQ-028 After release of rst_n, the first start SHALL be accepted at the next rising edge.

Verification
REQ-029 Add check: A=29, B=3, S=0 -> done 4 clocks later; sum=32, outc=0, borrow=0, overflow=0.
REQ-030 Subtract checks: A=21, B=83, S=1 -> sum=65474, outc=0, borrow=1, overflow=0; A=8, B=52, S=1 -> sum=65492, borrow=1.
REQ-031 Flag checks: A=16800, B=16900, S=0 -> sum=33700, outc=0, overflow=1; A=65534, B=65100, S=0 -> sum=65098, outc=1, overflow=0.
REQ-032 Handshake check: start held through RUN with operands changing every cycle -> exactly one result, computed from the operands at the accepting edge; a start during DONE (A=202, B=97, S=0) -> busy on the next cycle, and sum=299 four clocks later.
REQ-033 Reset check: assert rst_n=0 two clocks into RUN -> all outputs 0 immediately, and no done pulse follows.
REQ-034 Parameter check: an instance with WIDTH=8, DIGIT=1 and A=127, B=1, S=0 -> done after 8 clocks; sum=128, overflow=1, outc=0.

Source files
------------

// File: rtl/serial_addsub.sv
// rtl/serial_addsub.sv - digit-serial adder/subtractor, DIGIT bits per clock over WIDTH-bit operands
module serial_addsub #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] input1,
    input  logic [WIDTH-1:0] input2,
    input  logic             S,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             outc,
    output logic             borrow,
    output logic             overflow
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, res_reg;
    logic             carry, s_reg;
    logic [CW-1:0]    cnt;
    logic             accept, last, msb_cin;
    logic [DIGIT:0]   slice;
    logic [WIDTH-1:0] slice_ext, res_next;

    assign accept    = start && (state == IDLE || state == DONE);
    assign last      = (cnt == CW'(N - 1));
    assign slice     = {1'b0, a_reg[DIGIT-1:0]} + {1'b0, b_reg[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry};
    assign slice_ext = WIDTH'(slice[DIGIT-1:0]);
    // Slice results enter at the top so the LSB slice ends up at bit 0 after N shifts.
    assign res_next  = (res_reg >> DIGIT) | (slice_ext << (WIDTH - DIGIT));
    // On the top slice, the carry into the MSB is recovered from that bit's sum and operands.
    assign msb_cin   = slice[DIGIT-1] ^ a_reg[DIGIT-1] ^ b_reg[DIGIT-1];

    assign busy = (state == RUN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last)  state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            carry    <= 1'b0;
            s_reg    <= 1'b0;
            cnt      <= '0;
            sum      <= '0;
            outc     <= 1'b0;
            borrow   <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_reg   <= input1;
            b_reg   <= input2 ^ {WIDTH{S}};
            carry   <= S;
            s_reg   <= S;
            res_reg <= '0;
            cnt     <= '0;
        end else if (state == RUN) begin
            a_reg   <= a_reg >> DIGIT;
            b_reg   <= b_reg >> DIGIT;
            carry   <= slice[DIGIT];
            res_reg <= res_next;
            cnt     <= cnt + CW'(1);
            if (last) begin
                sum      <= res_next;
                outc     <= slice[DIGIT];
                borrow   <= s_reg & ~slice[DIGIT];
                overflow <= msb_cin ^ slice[DIGIT];
            end
        end
    end

endmodule

// File: tb/tb_serial_addsub.sv
// tb/tb_serial_addsub.sv - randomized and directed self-checking bench for serial_addsub
module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0, S = 1'b0;
    logic [15:0] input1 = '0, input2 = '0;
    logic        busy, done, outc, borrow, overflow;
    logic [15:0] sum;

    logic        start8 = 1'b0, s8 = 1'b0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy8, done8, outc8, borrow8, overflow8;
    logic [7:0]  sum8;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .input1(input1), .input2(input2), .S(S),
        .busy(busy), .done(done), .sum(sum), .outc(outc), .borrow(borrow), .overflow(overflow)
    );

    serial_addsub #(.WIDTH(8), .DIGIT(1)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .input1(a8), .input2(b8), .S(s8),
        .busy(busy8), .done(done8), .sum(sum8), .outc(outc8), .borrow(borrow8), .overflow(overflow8)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: ordinary integer arithmetic and sign rules.
    task automatic model(input int w, input longint a, input longint b, input logic s,
                         output longint r, output logic c, output logic bo, output logic ov);
        longint mask, full;
        logic sa, sb, sr;
        mask = (longint'(1) << w) - 1;
        full = s ? a + ((~b) & mask) + 1 : a + b;
        r  = full & mask;
        c  = ((full >> w) & 1) != 0;
        bo = s && (a < b);
        sa = ((a >> (w - 1)) & 1) != 0;
        sb = ((b >> (w - 1)) & 1) != 0;
        sr = ((r >> (w - 1)) & 1) != 0;
        ov = s ? (sa != sb && sr != sa) : (sa == sb && sr != sa);
    endtask

    // Called at the negedge just after the accepting edge; waits for done and checks results.
    task automatic finish_check(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s);
        longint r;
        logic c, bo, ov;
        int cyc;
        model(16, a, b, s, r, c, bo, ov);
        check({tag, "_busy"}, busy, 1);
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check({tag, "_lat"}, cyc, 4);
        check({tag, "_sum"}, sum, r[31:0]);
        check({tag, "_outc"}, outc, c);
        check({tag, "_borrow"}, borrow, bo);
        check({tag, "_ovf"}, overflow, ov);
    endtask

    task automatic op16(input string tag, input logic [15:0] a, input logic [15:0] b, input logic s);
        start = 1'b1; input1 = a; input2 = b; S = s;
        @(negedge clk);
        start = 1'b0; input1 = 16'($urandom); input2 = 16'($urandom); S = 1'($urandom);
        finish_check(tag, a, b, s);
        @(negedge clk);
        check({tag, "_done_drop"}, done, 0);
        check({tag, "_hold"}, sum, 32'(model_sum(a, b, s)));
    endtask

    function automatic logic [15:0] model_sum(input logic [15:0] a, input logic [15:0] b, input logic s);
        return s ? a - b : a + b;
    endfunction

    initial begin
        logic [15:0] ha, hb, ra, rb;
        logic hs, rs;
        int cyc;

        #1 rst_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sum", sum, 0);
        check("rst_flags", {outc, borrow, overflow}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op16("add29", 16'd29, 16'd3, 1'b0);
        op16("sub21", 16'd21, 16'd83, 1'b1);
        op16("sub8", 16'd8, 16'd52, 1'b1);
        op16("ovf", 16'd16800, 16'd16900, 1'b0);
        op16("carry", 16'd65534, 16'd65100, 1'b0);
        op16("subovf", 16'h8000, 16'd1, 1'b1);
        op16("subzero", 16'd1234, 16'd0, 1'b1);

        for (int i = 0; i < 20; i++) begin
            ra = 16'($urandom); rb = 16'($urandom); rs = 1'($urandom);
            if (i % 4 == 0) rb = ra;
            op16("rand", ra, rb, rs);
        end

        // start held through RUN with operands churning, then a start during DONE
        ha = 16'($urandom); hb = 16'($urandom); hs = 1'($urandom);
        start = 1'b1; input1 = ha; input2 = hb; S = hs;
        @(negedge clk);
        cyc = 0;
        while (!done && cyc < 40) begin
            input1 = 16'($urandom); input2 = 16'($urandom); S = 1'($urandom);
            @(negedge clk);
            cyc++;
        end
        check("hold_lat", cyc, 4);
        check("hold_sum", sum, model_sum(ha, hb, hs));
        input1 = 16'd202; input2 = 16'd97; S = 1'b0;
        @(negedge clk);
        start = 1'b0; input1 = 16'($urandom); input2 = 16'($urandom);
        check("b2b_done", done, 0);
        finish_check("b2b", 16'd202, 16'd97, 1'b0);
        @(negedge clk);

        // reset two clocks into RUN
        start = 1'b1; input1 = 16'd500; input2 = 16'd700; S = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_sum", sum, 0);
        check("abort_flags", {outc, borrow, overflow}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) cyc++;
        end
        check("abort_no_done", cyc, 0);
        op16("post_rst", 16'd1000, 16'd2345, 1'b1);

        // WIDTH=8, DIGIT=1 instance
        start8 = 1'b1; a8 = 8'd127; b8 = 8'd1; s8 = 1'b0;
        @(negedge clk);
        start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom);
        check("w8_busy", busy8, 1);
        cyc = 0;
        while (!done8 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("w8_lat", cyc, 8);
        check("w8_sum", sum8, 128);
        check("w8_ovf", overflow8, 1);
        check("w8_outc", outc8, 0);
        check("w8_borrow", borrow8, 0);

        for (int i = 0; i < 6; i++) begin
            longint r;
            logic c, bo, ov;
            logic [7:0] x, y;
            logic z;
            x = 8'($urandom); y = 8'($urandom); z = 1'($urandom);
            model(8, x, y, z, r, c, bo, ov);
            @(negedge clk);
            start8 = 1'b1; a8 = x; b8 = y; s8 = z;
            @(negedge clk);
            start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); s8 = 1'($urandom);
            cyc = 0;
            while (!done8 && cyc < 40) begin
                @(negedge clk);
                cyc++;
            end
            check("w8r_lat", cyc, 8);
            check("w8r_res", {sum8, outc8, borrow8, overflow8}, {r[7:0], c, bo, ov});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
